// File: rtl/countdown_timer_bank.sv
// Bank of NCH independent HH:MM:SS countdown timers, each with a preset, auto-reload and a buzz alarm.
// Latency: commands, digit writes and ticks act on the next clk_out edge; BCD display lags the count by one cycle.
// Backpressure: none; strobes are either acted on or ignored by the selected channel's state, never stalled.
module countdown_timer_bank #(
  parameter int NCH        = 4,
  parameter int BUZZ_TICKS = 5,
  parameter int CNT_W      = 17
) (
  input  logic                                        clk_out,
  input  logic                                        rst_n,
  input  logic                                        tick,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]    ch_sel,
  input  logic [2:0]                                  digit_sel,
  input  logic [3:0]                                  loadin,
  input  logic                                        load_en,
  input  logic                                        start,
  input  logic                                        pause,
  input  logic                                        clear,
  input  logic [NCH-1:0]                              reload_mode,
  output logic [NCH-1:0]                              busy,
  output logic [NCH-1:0]                              buzz,
  output logic [CNT_W-1:0]                            cnt_out,
  output logic [3:0]                                  th1,
  output logic [3:0]                                  th2,
  output logic [3:0]                                  tm1,
  output logic [3:0]                                  tm2,
  output logic [3:0]                                  ts1,
  output logic [3:0]                                  ts2
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C10   = CNT_W'(10);
  localparam logic [CNT_W-1:0] C60   = CNT_W'(60);
  localparam logic [CNT_W-1:0] C3600 = CNT_W'(3600);
  localparam logic [3:0]       BUZZ_INIT = 4'(BUZZ_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  // Preset digits are kept packed as {h1, h2, m1, m2, s1, s2}, 4 bits each,
  // so a single-digit write can be validated against the full candidate time.
  function automatic logic [CNT_W-1:0] to_sec(input logic [23:0] d);
    return CNT_W'(d[3:0])
         + CNT_W'(10)    * CNT_W'(d[7:4])
         + CNT_W'(60)    * CNT_W'(d[11:8])
         + CNT_W'(600)   * CNT_W'(d[15:12])
         + CNT_W'(3600)  * CNT_W'(d[19:16])
         + CNT_W'(36000) * CNT_W'(d[23:20]);
  endfunction

  // A candidate is legal only if every digit is in range and the hour stays below 24.
  function automatic logic digits_ok(input logic [23:0] d);
    logic ok;
    ok = (d[3:0]   <= 4'd9) && (d[7:4]   <= 4'd5) &&
         (d[11:8]  <= 4'd9) && (d[15:12] <= 4'd5) &&
         (d[23:20] <= 4'd2) &&
         (d[19:16] <= ((d[23:20] == 4'd2) ? 4'd3 : 4'd9));
    return ok;
  endfunction

  logic [CNT_W-1:0] count_all [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [SW-1:0] CH_ID = SW'(g);

    state_t           state_q, state_d;
    logic [23:0]      dig_q, dig_d;
    logic [23:0]      cand;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic             sel;

    assign sel          = (ch_sel == CH_ID);
    assign busy[g]      = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign buzz[g]      = (bcnt_q != 4'd0);
    assign count_all[g] = count_q;

    // Channel state register; reset aborts everything including any buzz in progress.
    always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= ST_IDLE;
        dig_q    <= '0;
        preset_q <= '0;
        count_q  <= '0;
        bcnt_q   <= '0;
      end else begin
        state_q  <= state_d;
        dig_q    <= dig_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        bcnt_q   <= bcnt_d;
      end
    end

    // Tick update first, then the highest-priority command applied to the post-tick state.
    always_comb begin
      state_d  = state_q;
      dig_d    = dig_q;
      preset_d = preset_q;
      count_d  = count_q;
      bcnt_d   = bcnt_q;
      cand     = dig_q;

      if (tick) begin
        case (state_q)
          ST_RUN: begin
            // Count 0 in RUN cannot normally occur; treating it as expiry keeps the count from wrapping.
            if (count_q <= ONE) begin
              count_d = '0;
              state_d = ST_EXPIRED;
              bcnt_d  = BUZZ_INIT;
            end else begin
              count_d = count_q - ONE;
            end
          end
          ST_EXPIRED: begin
            if (bcnt_q != 4'd0) begin
              bcnt_d = bcnt_q - 4'd1;
              if (bcnt_q == 4'd1) begin
                if (reload_mode[g]) begin
                  count_d = preset_q;
                  state_d = ST_RUN;
                end else begin
                  count_d = '0;
                end
              end
            end
          end
          default: ;
        endcase
      end

      case (digit_sel)
        3'd0:    cand[3:0]   = loadin;
        3'd1:    cand[7:4]   = loadin;
        3'd2:    cand[11:8]  = loadin;
        3'd3:    cand[15:12] = loadin;
        3'd4:    cand[19:16] = loadin;
        3'd5:    cand[23:20] = loadin;
        default: ;
      endcase

      if (sel) begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = preset_q;
          bcnt_d  = '0;
        end else if (start) begin
          case (state_d)
            ST_IDLE: begin
              if (preset_q != '0) state_d = ST_RUN;
            end
            ST_PAUSED: state_d = ST_RUN;
            ST_EXPIRED: begin
              count_d = preset_q;
              bcnt_d  = '0;
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end else if (pause) begin
          if (state_d == ST_RUN) state_d = ST_PAUSED;
        end else if (load_en) begin
          if ((state_q == ST_IDLE) && (digit_sel <= 3'd5) && digits_ok(cand)) begin
            dig_d    = cand;
            preset_d = to_sec(cand);
            count_d  = to_sec(cand);
          end
        end
      end
    end
  end

  logic [CNT_W-1:0] cnt_sel;
  logic [CNT_W-1:0] hrs, rem, mins, secs;

  // Selected-channel count mux; an out-of-range selection reads as zero.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == SW'(i)) cnt_sel = count_all[i];
    end
  end

  assign cnt_out = cnt_sel;
  assign hrs     = cnt_sel / C3600;
  assign rem     = cnt_sel % C3600;
  assign mins    = rem / C60;
  assign secs    = rem % C60;

  // Registered BCD display of the selected count, one cycle behind the count and ch_sel.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      th1 <= '0;
      th2 <= '0;
      tm1 <= '0;
      tm2 <= '0;
      ts1 <= '0;
      ts2 <= '0;
    end else begin
      th1 <= 4'(hrs / C10);
      th2 <= 4'(hrs % C10);
      tm1 <= 4'(mins / C10);
      tm2 <= 4'(mins % C10);
      ts1 <= 4'(secs / C10);
      ts2 <= 4'(secs % C10);
    end
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Bench for countdown_timer_bank: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts post-edge state; outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_countdown_timer_bank;

  localparam int NCH  = 4;
  localparam int BUZZ = 5;
  localparam int CW   = 17;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_EXP    = 3;

  logic           clk_out = 1'b0;
  logic           rst_n;
  logic           tick;
  logic [1:0]     ch_sel;
  logic [2:0]     digit_sel;
  logic [3:0]     loadin;
  logic           load_en, start, pause, clear;
  logic [NCH-1:0] reload_mode;
  logic [NCH-1:0] busy, buzz;
  logic [CW-1:0]  cnt_out;
  logic [3:0]     th1, th2, tm1, tm2, ts1, ts2;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: per-channel state in plain integers.
  int          m_state  [NCH];
  int          m_preset [NCH];
  int          m_count  [NCH];
  int          m_buzz   [NCH];
  int          m_dig    [NCH][6];
  int          lim      [6] = '{9, 5, 9, 5, 9, 2};
  logic [23:0] e_disp;

  countdown_timer_bank #(.NCH(NCH), .BUZZ_TICKS(BUZZ), .CNT_W(CW)) dut (
    .clk_out(clk_out), .rst_n(rst_n), .tick(tick), .ch_sel(ch_sel),
    .digit_sel(digit_sel), .loadin(loadin), .load_en(load_en),
    .start(start), .pause(pause), .clear(clear), .reload_mode(reload_mode),
    .busy(busy), .buzz(buzz), .cnt_out(cnt_out),
    .th1(th1), .th2(th2), .tm1(tm1), .tm2(tm2), .ts1(ts1), .ts2(ts2)
  );

  always #5 clk_out = ~clk_out;

  function automatic logic [23:0] bcd6(input int c);
    int h, mi, s;
    h  = c / 3600;
    mi = (c % 3600) / 60;
    s  = c % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_state[i] = S_IDLE; m_preset[i] = 0; m_count[i] = 0; m_buzz[i] = 0;
      for (int k = 0; k < 6; k++) m_dig[i][k] = 0;
    end
    e_disp = '0;
  endtask

  task automatic model_edge();
    int sel;
    int d[6];
    bit ok;
    sel = int'(ch_sel);
    e_disp = bcd6(m_count[sel]);
    for (int i = 0; i < NCH; i++) begin
      if (tick) begin
        if (m_state[i] == S_RUN) begin
          m_count[i] = m_count[i] - 1;
          if (m_count[i] == 0) begin m_state[i] = S_EXP; m_buzz[i] = BUZZ; end
        end else if (m_state[i] == S_EXP && m_buzz[i] > 0) begin
          m_buzz[i] = m_buzz[i] - 1;
          if (m_buzz[i] == 0) begin
            if (reload_mode[i]) begin m_count[i] = m_preset[i]; m_state[i] = S_RUN; end
            else m_count[i] = 0;
          end
        end
      end
      if (i == sel) begin
        if (clear) begin
          m_state[i] = S_IDLE; m_count[i] = m_preset[i]; m_buzz[i] = 0;
        end else if (start) begin
          if (m_state[i] == S_IDLE && m_preset[i] != 0) m_state[i] = S_RUN;
          else if (m_state[i] == S_PAUSED) m_state[i] = S_RUN;
          else if (m_state[i] == S_EXP) begin
            m_count[i] = m_preset[i]; m_buzz[i] = 0; m_state[i] = S_RUN;
          end
        end else if (pause) begin
          if (m_state[i] == S_RUN) m_state[i] = S_PAUSED;
        end else if (load_en && m_state[i] == S_IDLE && digit_sel < 3'd6) begin
          for (int k = 0; k < 6; k++) d[k] = m_dig[i][k];
          d[digit_sel] = int'(loadin);
          ok = 1'b1;
          for (int k = 0; k < 6; k++) if (d[k] > lim[k]) ok = 1'b0;
          if (d[5] == 2 && d[4] > 3) ok = 1'b0;
          if (ok) begin
            for (int k = 0; k < 6; k++) m_dig[i][k] = d[k];
            m_preset[i] = d[0] + 10 * d[1] + 60 * d[2] + 600 * d[3] + 3600 * d[4] + 36000 * d[5];
            m_count[i]  = m_preset[i];
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] eb, ez;
    logic [CW-1:0]  ec;
    logic [23:0]    ad;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = (m_state[i] == S_RUN) || (m_state[i] == S_PAUSED);
      ez[i] = (m_buzz[i] > 0);
    end
    ec = CW'(m_count[int'(ch_sel)]);
    ad = {th1, th2, tm1, tm2, ts1, ts2};
    checks++;
    assert (busy === eb) else begin failures++; $error("FAIL %s busy got=%b exp=%b", tag, busy, eb); end
    checks++;
    assert (buzz === ez) else begin failures++; $error("FAIL %s buzz got=%b exp=%b", tag, buzz, ez); end
    checks++;
    assert (cnt_out === ec) else begin failures++; $error("FAIL %s cnt_out got=%0d exp=%0d", tag, cnt_out, ec); end
    checks++;
    assert (ad === e_disp) else begin failures++; $error("FAIL %s bcd got=%h exp=%h", tag, ad, e_disp); end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk_out);
    model_edge();
    #1;
    check_all(tag);
    tick = 0; start = 0; pause = 0; clear = 0; load_en = 0;
  endtask

  task automatic wr(input int ch, input int d, input int v);
    ch_sel = 2'(ch); digit_sel = 3'(d); loadin = 4'(v); load_en = 1;
    cyc("write");
  endtask

  task automatic cmd_start(input int ch);
    ch_sel = 2'(ch); start = 1; cyc("start");
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1; cyc("tick");
      cyc("gap");
    end
  endtask

  initial begin
    rst_n = 0; tick = 0; ch_sel = 0; digit_sel = 0; loadin = 0;
    load_en = 0; start = 0; pause = 0; clear = 0; reload_mode = '0;
    model_reset();
    #1;
    check_all("reset");
    #11;
    rst_n = 1;

    // Load ch0 with 00:01:05, run it to expiry and through the buzz window.
    wr(0, 0, 5);
    wr(0, 2, 1);
    chk("preset_65", 32'(cnt_out), 65);
    cmd_start(0);
    tick_n(64);
    chk("ch0_cnt_1", 32'(cnt_out), 1);
    chk("ch0_busy_run", 32'(busy[0]), 1);
    tick_n(1);
    chk("ch0_expired_buzz", 32'(buzz[0]), 1);
    chk("ch0_expired_busy", 32'(busy[0]), 0);
    tick_n(4);
    chk("ch0_buzz_4", 32'(buzz[0]), 1);
    tick_n(1);
    chk("ch0_buzz_off", 32'(buzz[0]), 0);
    chk("ch0_cnt_zero", 32'(cnt_out), 0);
    chk("ch0_bcd_zero", 32'({th1, th2, tm1, tm2, ts1, ts2}), 0);

    // Hour-digit range rules on ch2.
    wr(2, 5, 2);
    chk("h1_2", 32'(cnt_out), 72000);
    wr(2, 4, 4);
    chk("h2_4_rejected", 32'(cnt_out), 72000);
    wr(2, 4, 3);
    chk("h2_3", 32'(cnt_out), 82800);
    wr(2, 6, 1);
    chk("digit6_ignored", 32'(cnt_out), 82800);
    wr(2, 1, 7);
    chk("s1_7_rejected", 32'(cnt_out), 82800);
    cyc("bcd_settle");
    chk("bcd_23h", 32'({th1, th2, tm1, tm2, ts1, ts2}), 32'h230000);

    // Auto-reload on ch1 while ch0 restarts from EXPIRED and runs concurrently.
    reload_mode = 4'b0010;
    wr(1, 0, 3);
    cmd_start(1);
    cmd_start(0);
    ch_sel = 1;
    tick_n(3);
    chk("ch1_buzz", 32'(buzz[1]), 1);
    chk("ch1_cnt0", 32'(cnt_out), 0);
    tick_n(5);
    chk("ch1_reload_cnt", 32'(cnt_out), 3);
    chk("ch1_reload_busy", 32'(busy[1]), 1);
    chk("ch1_buzz_off", 32'(buzz[1]), 0);
    ch_sel = 0;
    cyc("sel0");
    chk("ch0_concurrent", 32'(cnt_out), 57);

    // Pause on a tick, hold, resume; then clear beats start.
    wr(3, 1, 1);
    cmd_start(3);
    ch_sel = 3; tick = 1; pause = 1; cyc("tick_pause");
    chk("pause_cnt9", 32'(cnt_out), 9);
    chk("paused_busy", 32'(busy[3]), 1);
    tick_n(4);
    chk("paused_hold", 32'(cnt_out), 9);
    cmd_start(3);
    tick_n(1);
    chk("resume_cnt8", 32'(cnt_out), 8);
    ch_sel = 3; clear = 1; start = 1; cyc("clear_start");
    chk("clear_idle", 32'(busy[3]), 0);
    chk("clear_cnt", 32'(cnt_out), 10);

    // Zero preset cannot be started.
    wr(3, 1, 0);
    cmd_start(3);
    chk("zero_start_busy", 32'(busy[3]), 0);

    // Randomized traffic on all channels.
    for (int n = 0; n < 1500; n++) begin
      ch_sel    = 2'($urandom_range(0, 3));
      tick      = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 9) == 0);
      load_en   = ($urandom_range(0, 3) == 0);
      digit_sel = 3'($urandom_range(0, 7));
      loadin    = (digit_sel >= 3'd2 && $urandom_range(0, 3) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) reload_mode = 4'($urandom_range(0, 15));
      cyc("rand");
    end

    // Asynchronous reset in the middle of a countdown.
    ch_sel = 0; clear = 1; cyc("pre_clear");
    wr(0, 0, 9);
    cmd_start(0);
    tick_n(3);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 0);
    chk("arst_buzz", 32'(buzz), 0);
    chk("arst_cnt", 32'(cnt_out), 0);
    chk("arst_bcd", 32'({th1, th2, tm1, tm2, ts1, ts2}), 0);
    @(posedge clk_out);
    @(posedge clk_out);
    #1;
    check_all("in_reset");
    @(negedge clk_out);
    rst_n = 1;
    wr(0, 0, 7);
    chk("first_edge_write", 32'(cnt_out), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer_bank.md
COUNTDOWN_TIMER_BANK -- requirements
Module: countdown_timer_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent countdown channels (1..8).
REQ-002 Parameter BUZZ_TICKS, default 5: tick count for which a channel's buzz stays high on expiry (1..15).
REQ-003 Parameter CNT_W, default 17: width of each channel's seconds counter; it SHALL be at least 17.
REQ-004 clk_out  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 tick  in  1  one-cycle 1 Hz enable; all counting and buzz timing SHALL advance only on cycles with tick=1.
REQ-007 ch_sel  in  max(1,clog2(NCH))  selects the channel for load, command and display.
REQ-008 digit_sel  in  3  selects the digit: 0=s2, 1=s1, 2=m2, 3=m1, 4=h2, 5=h1; 6 and 7 are ignored.
REQ-009 loadin  in  4  BCD value for a digit write.
REQ-010 load_en  in  1  digit write strobe.
REQ-011 start, pause, clear  in  1 each  one-cycle command strobes to the selected channel.
REQ-012 reload_mode  in  NCH  per-channel auto-reload enable.
REQ-013 busy  out  NCH  channel is in RUN or PAUSED.
REQ-014 buzz  out  NCH  per-channel expiry alarm.
REQ-015 cnt_out  out  CNT_W  remaining seconds of the selected channel.
REQ-016 th1, th2, tm1, tm2, ts1, ts2  out  4 each  BCD HH:MM:SS of the selected channel.

Function
REQ-017 Each channel SHALL hold a preset register (seconds), a count register, a 4-bit buzz counter and one of the states IDLE, RUN, PAUSED or EXPIRED.
REQ-018 A digit write SHALL be accepted only in IDLE and only if the value is in range: s2,m2 ≤9; s1,m1 ≤5; h1 ≤2; h2 ≤9, or h2 ≤3 when h1=2. A write setting h1=2 while h2>3 SHALL be rejected.
REQ-019 Rejected writes and writes to digit_sel 6 or 7 SHALL change nothing.
REQ-020 On the cycle after an accepted write, the preset SHALL equal s2+10·s1+60·m2+600·m1+3600·h2+36000·h1, and the count SHALL equal the preset.
REQ-021 Command priority on the same cycle SHALL be: clear > start > pause > load_en; only the highest-priority command SHALL act.
REQ-022 clear, from any state, SHALL give IDLE, count=preset and buzz=0; the preset is kept.
REQ-023 start SHALL take IDLE to RUN when the preset is nonzero and PAUSED to RUN. With preset=0, start in IDLE SHALL be ignored. In EXPIRED, start SHALL reload the count from the preset, clear buzz and enter RUN.
REQ-024 pause SHALL take RUN to PAUSED and SHALL be ignored in all other states.
REQ-025 In RUN, each tick SHALL decrement the count. The tick that takes the count from 1 to 0 SHALL enter EXPIRED, set buzz=1 and load the buzz counter with BUZZ_TICKS.
REQ-026 In EXPIRED, each tick SHALL decrement the buzz counter, and buzz SHALL fall on the tick where it reaches 0. At that tick:
- with reload_mode=1, count SHALL be reloaded from the preset and the state SHALL return to RUN;
- with reload_mode=0, the state SHALL stay EXPIRED, buzz=0, count=0.
REQ-027 A start or pause on the same cycle as a tick SHALL take effect after that tick's update, so the decrement or expiry on that cycle still happens.
REQ-028 Channels not selected by ch_sel SHALL continue counting and are unaffected by commands.
REQ-029 The BCD outputs SHALL be registered from the selected count (hours = count/3600, minutes = (count mod 3600)/60, seconds = count mod 60), one cycle after the count or ch_sel changes.
REQ-030 cnt_out SHALL be combinational from the selected count.
REQ-031 Counts SHALL never underflow below 0 and SHALL never exceed 86399.

Reset
REQ-032 While rst_n=0, every channel SHALL have state=IDLE, preset=0, count=0 and buzz counter=0, and busy, buzz, cnt_out and all BCD outputs SHALL be 0.
REQ-033 Reset asserted mid-run SHALL abort immediately, with no buzz pulse and no partially applied write.
REQ-034 After rst_n rises, the first edge SHALL accept commands.

Verification
REQ-035 Load ch0 00:01:05, start, apply 65 ticks -> busy[0]=1 throughout, cnt_out goes 65→0, buzz[0]=1 for 5 ticks, then buzz=0, state EXPIRED, BCD output 00:00:00.
REQ-036 Write h1=2 then h2=4 -> h2 is rejected and preset=72000. Then write h2=3 -> preset=82800.
REQ-037 ch1 with reload_mode=1 and preset=3: start, 3 ticks -> buzz 5 ticks, then count=3 and RUN again; ch0 running concurrently is unaffected.
REQ-038 RUN count=10: pause at tick, 4 ticks idle, start -> count=9 holds during PAUSED, then resumes to 8 on the next tick. clear+start on the same cycle -> IDLE, count=preset.
REQ-039 Preset=0 then start -> stays IDLE and busy=0.
REQ-040 rst_n low mid-countdown -> all outputs 0 asynchronously.
